// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, widths and request legality check for the load/store unit
package lsu_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int WIDX_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    function automatic logic req_bad(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: req_bad = 1'b0;
            SZ_HALF: req_bad = addr_lo[0];
            SZ_WORD: req_bad = (addr_lo != 2'b00);
            default: req_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response handshake and data memory bus
interface load_store_unit_if;
    import lsu_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [1:0]          req_size;
    logic                req_signed;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_error;
    logic                mem_we;
    logic [WIDX_W-1:0]   mem_address;
    logic [DATA_W-1:0]   mem_data;
    logic [DATA_W-1:0]   mem_q;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_q,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_we, mem_address, mem_data
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_q,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, mem_we, mem_address, mem_data
    );

endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        addr_lo_i,
    input  size_e             size_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] load_o,
    output logic [DATA_W-1:0] merge_o
);

    logic [4:0]        shamt;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] mask;

    assign shamt = {addr_lo_i, 3'b000};
    assign lane  = word_i >> shamt;

    always_comb begin
        load_o = word_i;
        mask   = '1;
        case (size_i)
            SZ_BYTE: begin
                load_o = {{24{signed_i & lane[7]}}, lane[7:0]};
                mask   = 32'h0000_00FF;
            end
            SZ_HALF: begin
                load_o = {{16{signed_i & lane[15]}}, lane[15:0]};
                mask   = 32'h0000_FFFF;
            end
            default: ;
        endcase
        merge_o = (word_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store FSM driving a single-port word memory with sub-word read-modify-write
module load_store_unit
    import lsu_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    load_store_unit_if.slave  bus
);

    state_e            state_q;
    size_e             size_q;
    logic              signed_q;
    logic [1:0]        addr_lo_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mem_we_q;
    logic [WIDX_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_error_q;

    logic [DATA_W-1:0] load_d;
    logic [DATA_W-1:0] merge_d;
    size_e             req_size;

    assign req_size = size_e'(bus.req_size);

    lsu_lane_align u_align (
        .word_i    (bus.mem_q),
        .addr_lo_i (addr_lo_q),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .wdata_i   (wdata_q),
        .load_o    (load_d),
        .merge_o   (merge_d)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            size_q        <= SZ_BYTE;
            signed_q      <= 1'b0;
            addr_lo_q     <= '0;
            wdata_q       <= '0;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
        end else begin
            // Pulses default low; only the entry into WRITE/RESP raises them.
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        size_q        <= req_size;
                        signed_q      <= bus.req_signed;
                        addr_lo_q     <= bus.req_addr[1:0];
                        wdata_q       <= bus.req_wdata;
                        mem_address_q <= bus.req_addr[ADDR_W-1:2];
                        if (req_bad(req_size, bus.req_addr[1:0])) begin
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= ST_RESP;
                        end else if (!bus.req_write) begin
                            state_q <= ST_LOAD;
                        end else if (req_size == SZ_WORD) begin
                            mem_data_q <= bus.req_wdata;
                            mem_we_q   <= 1'b1;
                            state_q    <= ST_WRITE;
                        end else begin
                            state_q <= ST_RMW_READ;
                        end
                    end
                end
                ST_LOAD: begin
                    rsp_rdata_q <= load_d;
                    rsp_error_q <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RMW_READ: begin
                    mem_data_q <= merge_d;
                    mem_we_q   <= 1'b1;
                    state_q    <= ST_WRITE;
                end
                ST_WRITE: begin
                    rsp_rdata_q <= '0;
                    rsp_error_q <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_error   = rsp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a behavioural 1024-word memory
module tb_load_store_unit;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    load_store_unit_if bus();

    load_store_unit dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    logic [31:0] mem [1024];
    assign bus.mem_q = mem[bus.mem_address];
    always @(posedge CLK) if (bus.mem_we) mem[bus.mem_address] <= bus.mem_data;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   we_count = 0;
    int   rsp_count = 0;
    int   acc_count = 0;
    int   pushed = 0;
    logic acc_prev = 1'b0;
    logic [9:0] last_we_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Monitor: samples at the falling edge, away from DUT updates.
    always @(negedge CLK) begin
        if (RST_N) begin
            exp_t e;
            if (acc_prev) chk("ready_low_after_accept", {31'b0, bus.req_ready}, 32'd0);
            acc_prev = bus.req_valid && bus.req_ready;
            if (acc_prev) acc_count++;
            if (bus.mem_we) begin
                we_count++;
                last_we_addr = bus.mem_address;
            end
            if (bus.rsp_valid) begin
                rsp_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_error", {31'b0, bus.rsp_error}, {31'b0, e.err});
                    chk("rsp_latency", cyc - e.acc + 1, e.lat);
                end
            end
        end else begin
            acc_prev = 1'b0;
        end
    end

    // Called at posedge+2; returns at posedge+2 after the accept edge with req_valid still high.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg, input logic [11:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input logic push);
        exp_t e;
        bit   done = 0;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            if (bus.req_ready) begin
                if (push) begin
                    e.rdata = exp_rd; e.err = exp_err; e.acc = cyc + 1; e.lat = lat;
                    exp_q.push_back(e);
                    pushed++;
                end
                @(posedge CLK); #2;
                done = 1;
            end
        end
        if (!done) chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge CLK); n++;
        end
        if (exp_q.size() != 0) chk("rsp_timeout", exp_q.size(), 32'd0);
        repeat (2) @(posedge CLK);
        #2;
    endtask

    int we0;
    int acc0;
    int rsp0;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0;
        bus.req_signed = 0; bus.req_addr = 0; bus.req_wdata = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_rsp_error", {31'b0, bus.rsp_error}, 32'd0);
        chk("reset_mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("reset_mem_address", {22'b0, bus.mem_address}, 32'd0);
        chk("reset_mem_data", bus.mem_data, 32'd0);
        @(posedge CLK); #2;
        RST_N = 1'b1;
        @(posedge CLK); #2;

        // Reset during the WRITE cycle of a word store
        issue(1, 2'b10, 0, 12'h010, 32'h1234_5678, 0, 0, 2, 0);
        bus.req_valid = 0;
        @(negedge CLK); #1;
        chk("midwrite_we_high", {31'b0, bus.mem_we}, 32'd1);
        RST_N = 1'b0;
        #1;
        chk("midwrite_we_drop", {31'b0, bus.mem_we}, 32'd0);
        @(posedge CLK); #2;
        RST_N = 1'b1;
        #1;
        chk("midwrite_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("midwrite_mem4", mem[4], 32'h0);
        @(posedge CLK); #2;

        // Word store then load
        we0 = we_count;
        issue(1, 2'b10, 0, 12'h008, 32'hDEAD_BEEF, 32'h0, 0, 2, 1);
        bus.req_valid = 0;
        wait_idle();
        chk("word_store_we_pulses", we_count - we0, 32'd1);
        chk("word_store_we_addr", {22'b0, last_we_addr}, 32'd2);
        chk("word_store_mem2", mem[2], 32'hDEAD_BEEF);
        issue(0, 2'b10, 0, 12'h008, 0, 32'hDEAD_BEEF, 0, 2, 1);
        bus.req_valid = 0;
        wait_idle();

        // Byte read-modify-write
        we0 = we_count;
        issue(1, 2'b00, 0, 12'h009, 32'h0000_005A, 32'h0, 0, 3, 1);
        bus.req_valid = 0;
        wait_idle();
        chk("byte_rmw_we_pulses", we_count - we0, 32'd1);
        chk("byte_rmw_mem2", mem[2], 32'hDEAD_5AEF);

        // Load extension
        issue(0, 2'b00, 1, 12'h00B, 0, 32'hFFFF_FFDE, 0, 2, 1);
        issue(0, 2'b01, 0, 12'h00A, 0, 32'h0000_DEAD, 0, 2, 1);
        issue(0, 2'b01, 1, 12'h008, 0, 32'h0000_5AEF, 0, 2, 1);
        bus.req_valid = 0;
        wait_idle();

        // Errors: no memory write, one-cycle latency
        we0 = we_count;
        issue(0, 2'b10, 0, 12'h006, 0, 32'h0, 1, 1, 1);
        issue(1, 2'b01, 0, 12'h001, 32'hFFFF_FFFF, 32'h0, 1, 1, 1);
        issue(0, 2'b11, 0, 12'h000, 0, 32'h0, 1, 1, 1);
        bus.req_valid = 0;
        wait_idle();
        chk("error_no_we", we_count - we0, 32'd0);
        chk("error_mem2_intact", mem[2], 32'hDEAD_5AEF);

        // Back-to-back with req_valid held high
        acc0 = acc_count;
        rsp0 = rsp_count;
        issue(1, 2'b01, 0, 12'h00E, 32'hAAAA_1234, 32'h0, 0, 3, 1);
        issue(0, 2'b01, 1, 12'h00E, 0, 32'h0000_1234, 0, 2, 1);
        issue(1, 2'b00, 0, 12'h00C, 32'h0000_0080, 32'h0, 0, 3, 1);
        issue(0, 2'b00, 1, 12'h00C, 0, 32'hFFFF_FF80, 0, 2, 1);
        bus.req_valid = 0;
        wait_idle();
        chk("b2b_accepts", acc_count - acc0, 32'd4);
        chk("b2b_responses", rsp_count - rsp0, 32'd4);
        chk("b2b_mem3", mem[3], 32'h1234_0080);

        chk("total_responses", rsp_count, pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
